// File: rtl/uncache_pkg.sv
// Shared types and helpers for the uncached SRAM responder: bus payloads,
// access-size codes, FSM states and byte-lane mask helpers.
package uncache_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned TYPE_W = 6;
  localparam int unsigned STRB_W = 16;
  localparam int unsigned LANES  = 8;

  localparam logic [TYPE_W-1:0] TYPE_B = 6'd0;
  localparam logic [TYPE_W-1:0] TYPE_H = 6'd1;
  localparam logic [TYPE_W-1:0] TYPE_S = 6'd3;
  localparam logic [TYPE_W-1:0] TYPE_D = 6'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TYPE_W-1:0] typ;
    logic              req;
  } busr_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              rdy;
    logic              valid;
  } busr_rsp_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TYPE_W-1:0] typ;
    logic [STRB_W-1:0] strb;
    logic              req;
  } busw_req_t;

  typedef struct packed {
    logic rdy;
  } busw_rsp_t;

  // Unknown size codes fall back to a full doubleword
  function automatic logic [2:0] norm_type(input logic [TYPE_W-1:0] t);
    logic [2:0] span;
    unique case (t)
      TYPE_B:  span = 3'd0;
      TYPE_H:  span = 3'd1;
      TYPE_S:  span = 3'd3;
      default: span = 3'd7;
    endcase
    return span;
  endfunction

  // Lanes lo..min(lo+span,7); bytes past lane 7 are simply not enabled
  function automatic logic [LANES-1:0] mask_of(input logic [2:0] lo, input logic [2:0] span);
    logic [LANES-1:0] m;
    logic [3:0]       hi;
    hi = {1'b0, lo} + {1'b0, span};
    for (int i = 0; i < int'(LANES); i++) begin
      m[i] = (4'(i) >= {1'b0, lo}) && (4'(i) <= hi);
    end
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] lane_expand(input logic [LANES-1:0] m);
    logic [DATA_W-1:0] e;
    for (int b = 0; b < int'(LANES); b++) begin
      e[8*b +: 8] = {8{m[b]}};
    end
    return e;
  endfunction

endpackage

// File: rtl/uncache_sram_rsp_if.sv
// LSU uncached SRAM read/write bus bundle; master is the LSU, slave the responder.
interface uncache_sram_rsp_if;
  import uncache_pkg::*;

  busr_req_t sram_busr_req;
  busr_rsp_t sram_busr_rsp;
  busw_req_t sram_busw_req;
  busw_rsp_t sram_busw_rsp;

  modport master (
    output sram_busr_req,
    output sram_busw_req,
    input  sram_busr_rsp,
    input  sram_busw_rsp
  );

  modport slave (
    input  sram_busr_req,
    input  sram_busw_req,
    output sram_busr_rsp,
    output sram_busw_rsp
  );
endinterface

// File: rtl/uncache_sram_mem.sv
// Byte-writable 64-bit scratchpad with a combinational read port.
module uncache_sram_mem #(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned AW          = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [7:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uncache_sram_rsp.sv
// Responder for the LSU uncached SRAM buses: decodes sized accesses, serves them
// from the scratchpad, returns read data after RD_LATENCY and counts bad accesses.
module uncache_sram_rsp
  import uncache_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hA000_0000,
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned RD_LATENCY  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  uncache_sram_rsp_if.slave       bus,
  output logic [15:0]             err_cnt
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (RD_LATENCY > 2) ? $clog2(RD_LATENCY - 1) : 1;
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 3;

  busr_req_t rq;
  busw_req_t wq;
  assign rq = bus.sram_busr_req;
  assign wq = bus.sram_busw_req;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_rsp;

  logic [AW-1:0] r_idx_q;
  logic [2:0]    r_lo_q, r_span_q;
  logic          r_ok_q;
  logic [63:0]   re_data;
  logic          re_valid;

  // Write-side decode
  logic [31:0]   w_off;
  logic          w_in_range, w_cross, w_err;
  logic [2:0]    w_lo, w_span;
  logic [3:0]    w_hi;
  logic [AW-1:0] w_idx;
  assign w_off      = wq.addr - BASE_ADDR;
  assign w_in_range = (wq.addr >= BASE_ADDR) && ({1'b0, w_off} < SPAN_BYTES);
  assign w_idx      = w_off[AW+2:3];
  assign w_lo       = wq.addr[2:0];
  assign w_span     = norm_type(wq.typ);
  assign w_hi       = {1'b0, w_lo} + {1'b0, w_span};
  assign w_cross    = w_hi[3];
  assign w_err      = ~w_in_range | w_cross;

  // Read-side decode
  logic [31:0]   r_off;
  logic          r_in_range, r_cross, r_err;
  logic [2:0]    r_lo, r_span;
  logic [3:0]    r_hi;
  logic [AW-1:0] r_idx;
  assign r_off      = rq.addr - BASE_ADDR;
  assign r_in_range = (rq.addr >= BASE_ADDR) && ({1'b0, r_off} < SPAN_BYTES);
  assign r_idx      = r_off[AW+2:3];
  assign r_lo       = rq.addr[2:0];
  assign r_span     = norm_type(rq.typ);
  assign r_hi       = {1'b0, r_lo} + {1'b0, r_span};
  assign r_cross    = r_hi[3];
  assign r_err      = ~r_in_range | r_cross;

  logic unused_bits;
  assign unused_bits = ^{wq.strb, w_off[31:AW+3], w_off[2:0], r_off[31:AW+3], r_off[2:0]};

  // Handshakes: only in IDLE, write has priority, forced low during reset
  logic idle, w_rdy, r_rdy;
  assign idle  = (state_q == ST_IDLE);
  assign w_rdy = rst_n & idle & wq.req;
  assign r_rdy = rst_n & idle & rq.req & ~wq.req;

  // In IDLE the response is built from the live request (RD_LATENCY==1), else from the latch
  logic [AW-1:0] cur_idx;
  logic [2:0]    cur_lo, cur_span;
  logic          cur_ok;
  logic [63:0]   rd_word, rd_keep, rd_aligned;
  assign cur_idx    = idle ? r_idx      : r_idx_q;
  assign cur_lo     = idle ? r_lo       : r_lo_q;
  assign cur_span   = idle ? r_span     : r_span_q;
  assign cur_ok     = idle ? r_in_range : r_ok_q;
  assign rd_keep    = rd_word & lane_expand(mask_of(cur_lo, cur_span));
  assign rd_aligned = cur_ok ? (rd_keep >> {cur_lo, 3'b000}) : '0;

  uncache_sram_mem #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_mem (
    .clk   (clk),
    .we    (w_rdy & w_in_range),
    .be    (mask_of(w_lo, w_span)),
    .waddr (w_idx),
    .wdata (wq.data << {w_lo, 3'b000}),
    .raddr (cur_idx),
    .rdata (rd_word)
  );

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_rsp = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (r_rdy) begin
          if (RD_LATENCY == 1) begin
            state_d  = ST_RD_RESP;
            load_rsp = 1'b1;
          end else begin
            state_d = ST_RD_WAIT;
            cnt_d   = CNT_W'(RD_LATENCY - 2);
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = ST_RD_RESP;
          load_rsp = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RD_RESP: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      r_idx_q  <= '0;
      r_lo_q   <= '0;
      r_span_q <= '0;
      r_ok_q   <= 1'b0;
      re_data  <= '0;
      re_valid <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      re_valid <= load_rsp;
      if (load_rsp) re_data <= rd_aligned;
      if (r_rdy) begin
        r_idx_q  <= r_idx;
        r_lo_q   <= r_lo;
        r_span_q <= r_span;
        r_ok_q   <= r_in_range;
      end
      if (((w_rdy & w_err) | (r_rdy & r_err)) && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end

  assign bus.sram_busr_rsp = {re_data, r_rdy, re_valid};
  assign bus.sram_busw_rsp = w_rdy;

endmodule

// File: tb/tb_uncache_sram_rsp.sv
// Directed + random bench for uncache_sram_rsp against a byte-array model.
module tb_uncache_sram_rsp;
  import uncache_pkg::*;

  localparam logic [31:0] BASE   = 32'hA000_0000;
  localparam int          DEPTH  = 512;
  localparam int          LAT    = 2;
  localparam int          NBYTES = DEPTH * 8;

  logic        clk;
  logic        rst_n;
  logic [15:0] err_cnt;
  int          total;
  int          bad;
  int          exp_err;
  logic [7:0]  mem_m [NBYTES];

  uncache_sram_rsp_if bus ();

  uncache_sram_rsp #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .RD_LATENCY  (LAT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [5:0] t);
    case (t)
      6'd0:    return 1;
      6'd1:    return 2;
      6'd3:    return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int offset_of(input logic [31:0] a);
    return int'(longint'(a) - longint'(BASE));
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (off >= 0) && (off < longint'(NBYTES));
  endfunction

  function automatic void m_count_err(input logic [31:0] a, input logic [5:0] t);
    int lo;
    lo = int'(a[2:0]);
    if ((!in_rng(a) || (lo + nbytes(t) > 8)) && exp_err < 65535) exp_err++;
  endfunction

  // Byte k of the access lands in byte address addr+k, only while it stays in the word
  function automatic void m_write(input logic [31:0] a, input logic [63:0] d, input logic [5:0] t);
    int lo, off;
    lo  = int'(a[2:0]);
    off = offset_of(a);
    m_count_err(a, t);
    if (in_rng(a)) begin
      for (int k = 0; k < nbytes(t); k++) begin
        if (lo + k < 8) mem_m[off + k] = d[8*k +: 8];
      end
    end
  endfunction

  function automatic logic [63:0] m_read(input logic [31:0] a, input logic [5:0] t);
    logic [63:0] r;
    int lo, off;
    r   = '0;
    lo  = int'(a[2:0]);
    off = offset_of(a);
    if (in_rng(a)) begin
      for (int k = 0; k < nbytes(t); k++) begin
        if (lo + k < 8) r[8*k +: 8] = mem_m[off + k];
      end
    end
    return r;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [5:0] t,
                          input string tag, input bit check);
    @(posedge clk); #1;
    bus.sram_busw_req = '{addr: a, data: d, typ: t, strb: 16'($urandom), req: 1'b1};
    @(negedge clk);
    if (check) chk(64'(bus.sram_busw_rsp.rdy), 64'd1, tag);
    m_write(a, d, t);
    @(posedge clk); #1;
    bus.sram_busw_req = '0;
  endtask

  // Request already driven: wait for r_rdy, then measure latency and data
  task automatic finish_read(input logic [63:0] exp, input string tag);
    int waited, lat;
    waited = 0;
    @(negedge clk);
    while (!bus.sram_busr_rsp.rdy && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    chk(64'(bus.sram_busr_rsp.rdy), 64'd1, {tag, "_accept"});
    @(posedge clk); #1;
    bus.sram_busr_req = '0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.sram_busr_rsp.valid && lat < 20);
    chk(64'(lat), 64'(LAT), {tag, "_latency"});
    chk(bus.sram_busr_rsp.data, exp, {tag, "_data"});
    @(negedge clk);
    chk(64'(bus.sram_busr_rsp.valid), 64'd0, {tag, "_pulse"});
  endtask

  task automatic do_read(input logic [31:0] a, input logic [5:0] t, input string tag);
    logic [63:0] exp;
    exp = m_read(a, t);
    m_count_err(a, t);
    @(posedge clk); #1;
    bus.sram_busr_req = '{addr: a, typ: t, req: 1'b1};
    finish_read(exp, tag);
  endtask

  logic [31:0] ra;
  logic [5:0]  rt;
  logic [63:0] rd;
  logic [5:0]  types [7] = '{6'd0, 6'd1, 6'd3, 6'd7, 6'd2, 6'd5, 6'd63};

  initial begin
    total   = 0;
    bad     = 0;
    exp_err = 0;
    rst_n   = 1'b0;
    bus.sram_busr_req = '{addr: BASE, typ: 6'd7, req: 1'b1};
    bus.sram_busw_req = '{addr: BASE, data: 64'h1, typ: 6'd7, strb: 16'hFFFF, req: 1'b1};
    repeat (2) @(negedge clk);
    chk(64'(bus.sram_busr_rsp.valid), 64'd0, "rst_re_valid");
    chk(bus.sram_busr_rsp.data, 64'd0, "rst_re_data");
    chk(64'(bus.sram_busr_rsp.rdy), 64'd0, "rst_r_rdy");
    chk(64'(bus.sram_busw_rsp.rdy), 64'd0, "rst_w_rdy");
    chk(64'(err_cnt), 64'd0, "rst_err_cnt");
    bus.sram_busr_req = '0;
    bus.sram_busw_req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Fill the scratchpad so every later read has a defined expectation
    for (int w = 0; w < DEPTH; w++) begin
      do_write(BASE + 32'(w * 8), {$urandom, $urandom}, 6'd7, "fill", 1'b0);
    end

    do_write(32'hA000_0010, 64'h1122334455667788, 6'd7, "sd_rdy", 1'b1);
    do_read (32'hA000_0010, 6'd7, "ld_sd");
    do_write(32'hA000_0013, 64'h00000000000000AB, 6'd0, "sb_rdy", 1'b1);
    do_read (32'hA000_0010, 6'd7, "ld_after_sb");
    do_read (32'hA000_0016, 6'd1, "lh_hi");
    chk(64'(err_cnt), 64'(exp_err), "err_none");

    do_read (32'h9FFF_FFF0, 6'd3, "lw_below");
    do_write(32'hA000_1000, 64'hDEAD_BEEF_CAFE_F00D, 6'd3, "sw_above", 1'b1);
    do_read (32'hA000_0000, 6'd7, "ld_word0_unchanged");
    chk(64'(err_cnt), 64'(exp_err), "err_oor");
    do_read (32'hA000_0016, 6'd3, "lw_cross");
    do_write(32'hA000_0025, 64'h0102030405060708, 6'd7, "sd_cross", 1'b1);
    do_read (32'hA000_0020, 6'd7, "ld_after_cross");
    chk(64'(err_cnt), 64'(exp_err), "err_cross");

    // Simultaneous request: write wins, read follows and sees the new data
    @(posedge clk); #1;
    bus.sram_busw_req = '{addr: 32'hA000_0040, data: 64'h0F1E2D3C4B5A6978, typ: 6'd7, strb: 16'h0, req: 1'b1};
    bus.sram_busr_req = '{addr: 32'hA000_0040, typ: 6'd7, req: 1'b1};
    @(negedge clk);
    chk(64'(bus.sram_busw_rsp.rdy), 64'd1, "both_w_rdy");
    chk(64'(bus.sram_busr_rsp.rdy), 64'd0, "both_r_held");
    m_write(32'hA000_0040, 64'h0F1E2D3C4B5A6978, 6'd7);
    @(posedge clk); #1;
    bus.sram_busw_req = '0;
    rd = m_read(32'hA000_0040, 6'd7);
    m_count_err(32'hA000_0040, 6'd7);
    finish_read(rd, "both_rd");

    // Reset while a read is waiting
    @(posedge clk); #1;
    bus.sram_busr_req = '{addr: 32'hA000_0010, typ: 6'd7, req: 1'b1};
    @(negedge clk);
    chk(64'(bus.sram_busr_rsp.rdy), 64'd1, "mid_accept");
    @(posedge clk); #1;
    bus.sram_busr_req = '0;
    #2;
    rst_n = 1'b0;
    bus.sram_busw_req = '{addr: 32'hA000_0010, data: 64'h5555, typ: 6'd7, strb: 16'h0, req: 1'b1};
    #1;
    chk(64'(bus.sram_busr_rsp.valid), 64'd0, "mid_rst_valid");
    chk(bus.sram_busr_rsp.data, 64'd0, "mid_rst_data");
    chk(64'(err_cnt), 64'd0, "mid_rst_err");
    chk(64'(bus.sram_busw_rsp.rdy), 64'd0, "mid_rst_w_rdy");
    exp_err = 0;
    @(negedge clk);
    bus.sram_busw_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk(64'(bus.sram_busr_rsp.valid), 64'd0, "post_rst_no_valid");
    end
    do_read(32'hA000_0010, 6'd7, "post_rst_ld");

    // Random mix, mostly in range with some out-of-range and odd sizes
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0:       ra = BASE - 32'($urandom_range(1, 64));
        1:       ra = BASE + 32'(NBYTES) + 32'($urandom_range(0, 64));
        default: ra = BASE + 32'($urandom_range(0, NBYTES - 1));
      endcase
      rt = types[$urandom_range(0, 6)];
      if ($urandom_range(0, 1) == 0) begin
        do_write(ra, {$urandom, $urandom}, rt, "rnd_wr", 1'b1);
      end else begin
        do_read(ra, rt, "rnd_rd");
      end
      chk(64'(err_cnt), 64'(exp_err), "rnd_err_cnt");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
